// File: rtl/period_seq_8bit_pkg.sv
// Shared definitions for the period sequencer.
//   state_t    : FSM state encoding (IDLE/LOAD/ARM/RUN)
//   DW_DEFAULT : default reload value width, matching the downstream 8-bit stage
package period_seq_8bit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ARM  = 2'b10,
        RUN  = 2'b11
    } state_t;

    localparam int DW_DEFAULT = 8;

endpackage

// File: rtl/period_seq_8bit_if.sv
// Bus bundle between the sequencer and its controller/downstream stage.
//   Table write : wr_en, wr_addr, wr_data
//   Control     : num_seg, loop_en, start, stop, tc_in
//   Outputs     : load, re_load, data_out, seg_idx, busy, seq_done, err
// The master modport drives the controls; the slave modport is the sequencer.
interface period_seq_8bit_if
    import period_seq_8bit_pkg::*;
#(
    parameter int AW = 2,
    parameter int DW = DW_DEFAULT
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   num_seg;
    logic          loop_en;
    logic          start;
    logic          stop;
    logic          tc_in;
    logic          load;
    logic          re_load;
    logic [DW-1:0] data_out;
    logic [AW-1:0] seg_idx;
    logic          busy;
    logic          seq_done;
    logic          err;

    modport master (
        output wr_en, wr_addr, wr_data, num_seg, loop_en, start, stop, tc_in,
        input  load, re_load, data_out, seg_idx, busy, seq_done, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, num_seg, loop_en, start, stop, tc_in,
        output load, re_load, data_out, seg_idx, busy, seq_done, err
    );
endinterface

// File: rtl/period_table.sv
// Reload value table: DEPTH x DW register file.
//   clk, rst          : clock, asynchronous active-low clear of all entries
//   wr_en/wr_addr/wr_data : single write port, captured on the rising edge
//   rd_addr/rd_data   : combinational read port
module period_table #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Register file rather than block RAM: the sequencer needs the entry in
    // the same cycle it decides to program it, and reset must clear it.
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/period_seq_8bit.sv
// Period sequencer: programs a table of reload values into the downstream
// 8-bit counter/reload stage, one segment per terminal count.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of period_seq_8bit_if (table write, control, outputs)
// Every output is a register; the *_next values are computed one cycle ahead
// so that load is high exactly while the FSM sits in LOAD and re_load while
// it sits in ARM.
module period_seq_8bit
    import period_seq_8bit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = DW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    period_seq_8bit_if.slave   bus
);
    state_t        state_reg, state_next;
    logic [AW:0]   num_seg_reg, num_seg_next;
    logic          loop_en_reg, loop_en_next;
    logic [AW-1:0] seg_idx_reg, seg_idx_next;
    logic [DW-1:0] data_out_reg, data_out_next;
    logic          load_reg, load_next;
    logic          re_load_reg, re_load_next;
    logic          busy_reg, busy_next;
    logic          seq_done_reg, seq_done_next;
    logic          err_reg, err_next;

    logic          tbl_we;
    logic [DW-1:0] tbl_rd_data;
    logic          start_ok;
    logic          last_seg;

    period_table #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tbl_we),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (seg_idx_next),
        .rd_data (tbl_rd_data)
    );

    assign start_ok = (bus.num_seg != '0) && (bus.num_seg <= (AW+1)'(DEPTH));
    assign last_seg = ({1'b0, seg_idx_reg} == (num_seg_reg - (AW+1)'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            num_seg_reg  <= '0;
            loop_en_reg  <= 1'b0;
            seg_idx_reg  <= '0;
            data_out_reg <= '0;
            load_reg     <= 1'b0;
            re_load_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            seq_done_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            num_seg_reg  <= num_seg_next;
            loop_en_reg  <= loop_en_next;
            seg_idx_reg  <= seg_idx_next;
            data_out_reg <= data_out_next;
            load_reg     <= load_next;
            re_load_reg  <= re_load_next;
            busy_reg     <= busy_next;
            seq_done_reg <= seq_done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        num_seg_next  = num_seg_reg;
        loop_en_next  = loop_en_reg;
        seg_idx_next  = seg_idx_reg;
        data_out_next = data_out_reg;
        load_next     = 1'b0;
        re_load_next  = 1'b0;
        seq_done_next = 1'b0;
        err_next      = 1'b0;
        tbl_we        = 1'b0;

        if (state_reg == IDLE) begin
            tbl_we = bus.wr_en;
            if (bus.start && !bus.stop) begin
                if (start_ok) begin
                    state_next    = LOAD;
                    num_seg_next  = bus.num_seg;
                    loop_en_next  = bus.loop_en;
                    seg_idx_next  = '0;
                    load_next     = 1'b1;
                    data_out_next = tbl_rd_data;
                end else begin
                    err_next = 1'b1;
                end
            end
        end else begin
            // Writes while a pass is running would change a value mid-pass.
            err_next = bus.wr_en;
            if (bus.stop) begin
                state_next = IDLE;
            end else begin
                case (state_reg)
                    LOAD: begin
                        state_next   = ARM;
                        re_load_next = 1'b1;
                    end
                    ARM: begin
                        state_next = RUN;
                    end
                    RUN: begin
                        if (bus.tc_in) begin
                            if (!last_seg) begin
                                seg_idx_next  = seg_idx_reg + AW'(1);
                                state_next    = LOAD;
                                load_next     = 1'b1;
                                data_out_next = tbl_rd_data;
                            end else if (loop_en_reg) begin
                                seg_idx_next  = '0;
                                state_next    = LOAD;
                                load_next     = 1'b1;
                                data_out_next = tbl_rd_data;
                            end else begin
                                seq_done_next = 1'b1;
                                state_next    = IDLE;
                            end
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        busy_next = (state_next != IDLE);
    end

    assign bus.load     = load_reg;
    assign bus.re_load  = re_load_reg;
    assign bus.data_out = data_out_reg;
    assign bus.seg_idx  = seg_idx_reg;
    assign bus.busy     = busy_reg;
    assign bus.seq_done = seq_done_reg;
    assign bus.err      = err_reg;
endmodule

// File: tb/tb_period_seq_8bit.sv
// Scoreboard bench for period_seq_8bit: stimulus pushes expected load /
// seq_done / err events, a negedge monitor pops and compares them.
module tb_period_seq_8bit;
    localparam int K_LOAD = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic [1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_load = 1'b0;

    period_seq_8bit_if #(.AW(2), .DW(8)) bus ();

    period_seq_8bit #(.DEPTH(4), .AW(2), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] data, input logic [1:0] idx);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.idx  = idx;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int kind, input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got event, expected none at %0t", name, $time);
        end else begin
            e = sb.pop_front();
            check({name, "_kind"}, kind, e.kind);
            if (kind == K_LOAD) begin
                check("load_data", {24'd0, bus.data_out}, {24'd0, e.data});
                check("load_idx", {30'd0, bus.seg_idx}, {30'd0, e.idx});
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            if (prev_load || bus.re_load)
                check("re_load_follows_load", {31'd0, bus.re_load}, {31'd0, prev_load});
            if (bus.load) begin
                $display("load     data_out=0x%02h seg_idx=%0d", bus.data_out, bus.seg_idx);
                pop_check(K_LOAD, "load");
            end
            if (bus.seq_done) begin
                $display("seq_done");
                pop_check(K_DONE, "seq_done");
            end
            if (bus.err) begin
                $display("err");
                pop_check(K_ERR, "err");
            end
        end
        prev_load = rst && bus.load;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        $display("write    mem[%0d]=0x%02h", a, d);
    endtask

    task automatic start_seq(input logic [2:0] n, input logic lp);
        bus.num_seg = n; bus.loop_en = lp; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        $display("start    num_seg=%0d loop_en=%0d", n, lp);
    endtask

    // From a LOAD cycle: step through ARM into RUN, wait `hold` cycles, pulse tc_in.
    task automatic seg_tc(input int kind, input logic [7:0] d, input logic [1:0] idx, input int hold);
        tick();
        tick();
        for (int i = 0; i < hold; i++) tick();
        expect_ev(kind, d, idx);
        bus.tc_in = 1'b1;
        tick();
        bus.tc_in = 1'b0;
        $display("tc_in    pulse");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.num_seg = 0;
        bus.loop_en = 0; bus.start = 0; bus.stop = 0; bus.tc_in = 0;

        // Reset state
        tick();
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_load", {31'd0, bus.load}, 0);
        check("rst_data_out", {24'd0, bus.data_out}, 0);
        tick();
        rst = 1'b1;
        tick();

        write_tbl(2'd0, 8'h10);
        write_tbl(2'd1, 8'h20);
        write_tbl(2'd2, 8'h30);
        write_tbl(2'd3, 8'h40);

        // Three segments, no loop
        expect_ev(K_LOAD, 8'h10, 2'd0);
        start_seq(3'd3, 1'b0);
        check("busy_in_load", {31'd0, bus.busy}, 1);
        seg_tc(K_LOAD, 8'h20, 2'd1, 2);
        seg_tc(K_LOAD, 8'h30, 2'd2, 0);
        seg_tc(K_DONE, 8'h00, 2'd0, 1);
        check("busy_after_done", {31'd0, bus.busy}, 0);
        check("data_out_holds_idle", {24'd0, bus.data_out}, 32'h30);
        tick(); tick();

        // Two segments, looping
        expect_ev(K_LOAD, 8'h10, 2'd0);
        start_seq(3'd2, 1'b1);
        seg_tc(K_LOAD, 8'h20, 2'd1, 0);
        seg_tc(K_LOAD, 8'h10, 2'd0, 1);
        seg_tc(K_LOAD, 8'h20, 2'd1, 0);
        seg_tc(K_LOAD, 8'h10, 2'd0, 0);
        // stop coincident with tc_in in RUN
        tick(); tick();
        bus.stop = 1'b1; bus.tc_in = 1'b1;
        tick();
        bus.stop = 1'b0; bus.tc_in = 1'b0;
        $display("stop     with tc_in");
        check("busy_after_stop", {31'd0, bus.busy}, 0);
        check("load_after_stop", {31'd0, bus.load}, 0);
        tick(); tick();

        // Write while busy is rejected; start held in RUN is ignored
        expect_ev(K_LOAD, 8'h10, 2'd0);
        start_seq(3'd3, 1'b0);
        bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 8'hEE;
        expect_ev(K_ERR, 8'h00, 2'd0);
        tick();
        bus.wr_en = 1'b0;
        tick();
        bus.start = 1'b1; bus.num_seg = 3'd1;
        tick(); tick(); tick();
        expect_ev(K_LOAD, 8'h20, 2'd1);
        bus.tc_in = 1'b1;
        tick();
        bus.tc_in = 1'b0; bus.start = 1'b0;
        check("busy_after_start_in_run", {31'd0, bus.busy}, 1);
        tick(); tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("busy_after_stop2", {31'd0, bus.busy}, 0);
        tick();

        // Rejected starts
        expect_ev(K_ERR, 8'h00, 2'd0);
        start_seq(3'd0, 1'b0);
        check("busy_num_seg0", {31'd0, bus.busy}, 0);
        tick();
        expect_ev(K_ERR, 8'h00, 2'd0);
        start_seq(3'd5, 1'b0);
        check("busy_num_seg5", {31'd0, bus.busy}, 0);
        tick();

        // num_seg=1 looping, then reset mid-RUN
        expect_ev(K_LOAD, 8'h10, 2'd0);
        start_seq(3'd1, 1'b1);
        seg_tc(K_LOAD, 8'h10, 2'd0, 0);
        seg_tc(K_LOAD, 8'h10, 2'd0, 1);
        tick(); tick();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 0);
        check("midrst_load", {31'd0, bus.load}, 0);
        check("midrst_re_load", {31'd0, bus.re_load}, 0);
        check("midrst_data_out", {24'd0, bus.data_out}, 0);
        check("midrst_seg_idx", {30'd0, bus.seg_idx}, 0);
        tick();
        rst = 1'b1;
        tick();
        expect_ev(K_LOAD, 8'h00, 2'd0);
        start_seq(3'd1, 1'b0);
        seg_tc(K_DONE, 8'h00, 2'd0, 0);
        tick(); tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/period_seq_8bit.md
Name: period_seq_8bit

Overview:
Period sequencer that drives the 8-bit counter/reload-register stage. Holds a small table of reload values and programs them into the stage in order, one segment per terminal count. Each segment's value is written via load/data_out, then the counter is restarted via re_load. Sits directly upstream: its load, re_load and data_out feed the stage's load, re_load and data_in; the stage's tc returns as tc_in.

Parameters:
DEPTH, 4, number of table entries (power of two, 2..16)
AW, 2, table address width, log2(DEPTH)
DW, 8, reload value width; matches the downstream stage

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
wr_en  in  1  table write strobe
wr_addr  in  AW  table write address
wr_data  in  DW  table write data
num_seg  in  AW+1  segments per pass (1..DEPTH), latched at start
loop_en  in  1  1 = restart at entry 0 after the last segment; latched at start
start  in  1  begin sequence (level, sampled in IDLE)
stop  in  1  abort sequence
tc_in  in  1  terminal count from the downstream stage
load  out  1  one-cycle strobe: downstream register captures data_out
re_load  out  1  one-cycle strobe: downstream counter restarts
data_out  out  DW  value being programmed
seg_idx  out  AW  index of the current segment
busy  out  1  high in every state except IDLE
seq_done  out  1  one-cycle pulse at end of a non-looping pass
err  out  1  one-cycle pulse on a rejected write or rejected start

Behaviour:
- Reset (rst=0, async): FSM=IDLE; all table entries 0; all outputs 0; latched num_seg/loop_en cleared.
- Table writes accepted only in IDLE: mem[wr_addr] <= wr_data at the edge.
- wr_en while busy: write dropped, err pulses the next cycle.
- All outputs are registered.
- FSM states: IDLE, LOAD, ARM, RUN.
- IDLE -> LOAD: start=1, stop=0, 1<=num_seg<=DEPTH. Latch num_seg and loop_en; seg_idx<=0.
- IDLE, start with num_seg=0 or num_seg>DEPTH: stay IDLE, err pulses.
- LOAD: load=1 and data_out=mem[seg_idx] for exactly one cycle; -> ARM.
- ARM: re_load=1 for exactly one cycle; data_out holds; -> RUN.
- RUN: load=re_load=0; wait for tc_in=1.
- RUN, tc_in=1, seg_idx < num_seg-1: seg_idx+1, -> LOAD.
- RUN, tc_in=1, seg_idx = num_seg-1, loop_en=1: seg_idx<=0, -> LOAD.
- RUN, tc_in=1, seg_idx = num_seg-1, loop_en=0: seq_done pulses, -> IDLE.
- Latency from tc_in high in RUN: load on the next cycle, re_load on the cycle after.
- tc_in outside RUN is ignored.
- stop=1 in any non-IDLE state: -> IDLE next edge; load/re_load forced 0 that cycle; no seq_done. stop has priority over tc_in and start.
- start while busy: ignored; no error.
- data_out and seg_idx hold their last values in IDLE.
- seg_idx wraps only through loop_en, never by overflow.
- num_seg=1 with loop_en=1: entry 0 is reprogrammed on every tc_in.
- Reset asserted mid-sequence: immediate return to IDLE; table contents lost.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, LOAD=2'b01, ARM=2'b10, RUN=2'b11) and DW default constant.
- One sub-module, period_table: DEPTH x DW register file, one write port, one combinational read port, async active-low clear.
- FSM, index counter and output registers stay in the top.

Test Plan:
1. Reset values: rst low mid-RUN -> all outputs 0 immediately; the first start afterwards programs data_out=0x00.
2. Table {0x10,0x20,0x30,0x40}, num_seg=3, loop_en=0, start. Expected:
   - load cycles carry data_out 0x10, then 0x20, then 0x30, each followed next cycle by re_load.
   - After the 3rd tc_in: seq_done pulses once, busy falls.
3. Same table, num_seg=2, loop_en=1 -> data_out sequence 0x10,0x20,0x10,0x20 across 4 tc_in pulses; seq_done never asserts.
4. stop asserted on the same cycle as tc_in in RUN -> IDLE next cycle, no load, no seq_done.
5. wr_en to addr 1 while busy -> err pulses, mem[1] unchanged (next pass still outputs 0x20).
6. start with num_seg=0 -> err pulses, busy stays 0. start held high during RUN -> no effect.
